// File: rtl/requant_pkg.sv
// Shared requantizer definitions: FSM states, channel count and sample widths,
// plus the 8-bit to 12-bit dequantization helper.
package requant_pkg;

  typedef enum logic [1:0] {
    WaitArm  = 2'd0,
    WaitSync = 2'd1,
    Running  = 2'd2
  } requant_state_t;

  localparam int unsigned REQ_NCHAN = 2048;
  localparam int unsigned REQ_IN_W  = 12;
  localparam int unsigned REQ_OUT_W = 8;
  localparam int unsigned REQ_SHIFT = 4;

  // Zero-filled left shift; the 8-bit sign bit lands in bit 11.
  function automatic logic [REQ_IN_W-1:0] dequant(input logic [REQ_OUT_W-1:0] v);
    return {v, {REQ_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/requant_unpack_sample.sv
// Splits one packed {re8, im8} word, restores 12-bit components and, when
// REQUANT_UNPACK_POWER_EN is defined, computes re^2 + im^2.
module requant_unpack_sample
  import requant_pkg::*;
(
  input  logic [2*REQ_OUT_W-1:0] word_i,
`ifdef REQUANT_UNPACK_POWER_EN
  output logic [15:0]            power_o,
`endif
  output logic [2*REQ_IN_W-1:0]  deq_o
);

  logic [REQ_OUT_W-1:0] re;
  logic [REQ_OUT_W-1:0] im;

  assign re    = word_i[2*REQ_OUT_W-1:REQ_OUT_W];
  assign im    = word_i[REQ_OUT_W-1:0];
  assign deq_o = {dequant(re), dequant(im)};

`ifdef REQUANT_UNPACK_POWER_EN
  logic signed [15:0] re_x;
  logic signed [15:0] im_x;
  logic signed [15:0] re_sq;
  logic signed [15:0] im_sq;

  assign re_x  = {{(16 - REQ_OUT_W){re[REQ_OUT_W-1]}}, re};
  assign im_x  = {{(16 - REQ_OUT_W){im[REQ_OUT_W-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  // Each square is at most 16384, so the unsigned sum tops out at 32768.
  assign power_o = re_sq + im_sq;
`endif

endmodule

// File: rtl/requant_unpack.sv
// Receive-side unpacker: aligns to the frame marker, restores 24-bit samples,
// tags channels and keeps frame/sync-error/overflow statistics.
// Optional power output enabled by defining REQUANT_UNPACK_POWER_EN.
module requant_unpack
  import requant_pkg::*;
#(
  parameter int unsigned NCHAN   = REQ_NCHAN,
  parameter int unsigned CHAN_W  = 11,
  parameter int unsigned FRAME_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    arm,
  input  logic                    sync_in,
  input  logic [2*REQ_OUT_W-1:0]  data_in,
  input  logic                    ovf_in,
  output logic [2*REQ_IN_W-1:0]   data_out,
  output logic                    valid_out,
  output logic [CHAN_W-1:0]       chan_out,
  output logic                    sync_out,
  output logic [FRAME_W-1:0]      frame_count,
  output logic                    sync_err,
`ifdef REQUANT_UNPACK_POWER_EN
  output logic [15:0]             power_out,
`endif
  output logic [15:0]             ovf_count
);

  localparam logic [CHAN_W-1:0] LastChan = CHAN_W'(NCHAN - 1);

  requant_state_t state_q, state_d;
  logic [CHAN_W-1:0] next_chan_q, next_chan_d;
  logic [CHAN_W-1:0] chan_adv;

  logic [2*REQ_IN_W-1:0] data_q;
  logic                  valid_q;
  logic [CHAN_W-1:0]     chan_q;
  logic                  sync_q;
  logic [FRAME_W-1:0]    frame_q;
  logic                  err_q;
  logic [15:0]           ovf_q;

  logic                  emit;
  logic                  sync_bad;
  logic [2*REQ_IN_W-1:0] deq;

`ifdef REQUANT_UNPACK_POWER_EN
  logic [15:0] power;
  logic [15:0] power_q;
`endif

  requant_unpack_sample u_sample (
    .word_i  (data_in),
`ifdef REQUANT_UNPACK_POWER_EN
    .power_o (power),
`endif
    .deq_o   (deq)
  );

  assign chan_adv = (next_chan_q == LastChan) ? '0 : next_chan_q + CHAN_W'(1);

  always_comb begin
    state_d     = state_q;
    next_chan_d = next_chan_q;
    emit        = 1'b0;
    sync_bad    = 1'b0;
    if (ce) begin
      case (state_q)
        WaitArm: begin
          if (arm) state_d = WaitSync;
        end
        WaitSync: begin
          if (sync_in) begin
            state_d     = Running;
            next_chan_d = '0;
          end
        end
        Running: begin
          // The word sharing a cycle with sync_in still belongs to the old frame position.
          emit        = 1'b1;
          next_chan_d = chan_adv;
          if (arm) begin
            state_d = WaitSync;
          end else if (sync_in) begin
            next_chan_d = '0;
            sync_bad    = (chan_adv != '0);
          end
        end
        default: state_d = WaitArm;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= WaitArm;
      next_chan_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      chan_q      <= '0;
      sync_q      <= 1'b0;
      frame_q     <= '0;
      err_q       <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      next_chan_q <= next_chan_d;
      valid_q     <= emit;
      sync_q      <= emit && (next_chan_q == '0);
      if (emit) begin
        data_q <= deq;
        chan_q <= next_chan_q;
      end
      if (emit && (next_chan_q == LastChan)) frame_q <= frame_q + FRAME_W'(1);
      if (sync_bad) err_q <= 1'b1;
      if (emit && ovf_in && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
    end
  end

`ifdef REQUANT_UNPACK_POWER_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      power_q <= '0;
    end else if (emit) begin
      power_q <= power;
    end
  end

  assign power_out = power_q;
`endif

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign chan_out    = chan_q;
  assign sync_out    = sync_q;
  assign frame_count = frame_q;
  assign sync_err    = err_q;
  assign ovf_count   = ovf_q;

endmodule

// File: tb/tb_requant_unpack.sv
// Scoreboard bench for requant_unpack: a frame-level reference model predicts
// each emitted word; a monitor pops and compares whenever valid_out is seen.
module tb_requant_unpack;

  localparam int NCH = 2048;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        arm;
  logic        sync_in;
  logic [15:0] data_in;
  logic        ovf_in;
  logic [23:0] data_out;
  logic        valid_out;
  logic [10:0] chan_out;
  logic        sync_out;
  logic [15:0] frame_count;
  logic        sync_err;
  logic [15:0] ovf_count;
`ifdef REQUANT_UNPACK_POWER_EN
  logic [15:0] power_out;
`endif

  requant_unpack #(
    .NCHAN   (2048),
    .CHAN_W  (11),
    .FRAME_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .arm         (arm),
    .sync_in     (sync_in),
    .data_in     (data_in),
    .ovf_in      (ovf_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .chan_out    (chan_out),
    .sync_out    (sync_out),
    .frame_count (frame_count),
    .sync_err    (sync_err),
`ifdef REQUANT_UNPACK_POWER_EN
    .power_out   (power_out),
`endif
    .ovf_count   (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    int          chan;
    logic        sync;
    int          pwr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: frame position as a plain integer.
  bit m_armed, m_locked, m_err;
  int m_pos, m_frames, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_armed  = 0;
    m_locked = 0;
    m_err    = 0;
    m_pos    = 0;
    m_frames = 0;
    m_ovf    = 0;
    exp_q.delete();
  endtask

  function automatic logic [11:0] deq12(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    return 12'(s * 16);
  endfunction

  task automatic model(input bit c, input bit a, input bit s, input logic [15:0] d,
                       input bit o);
    exp_t e;
    int   r, i;
    if (!c) return;
    if (m_locked) begin
      r      = int'($signed(d[15:8]));
      i      = int'($signed(d[7:0]));
      e.data = {deq12(d[15:8]), deq12(d[7:0])};
      e.chan = m_pos;
      e.sync = (m_pos == 0);
      e.pwr  = r * r + i * i;
      exp_q.push_back(e);
      if (o && m_ovf < 65535) m_ovf++;
      if (m_pos == NCH - 1) m_frames = (m_frames + 1) % 65536;
      m_pos = (m_pos + 1) % NCH;
      if (a) begin
        m_locked = 0;
      end else if (s) begin
        if (m_pos != 0) m_err = 1;
        m_pos = 0;
      end
    end else if (m_armed) begin
      if (s) begin
        m_locked = 1;
        m_pos    = 0;
      end
    end else if (a) begin
      m_armed = 1;
    end
  endtask

  task automatic step(input bit c, input bit a, input bit s, input logic [15:0] d,
                      input bit o);
    @(negedge clk);
    ce      = c;
    arm     = a;
    sync_in = s;
    data_in = d;
    ovf_in  = o;
    model(c, a, s, d, o);
  endtask

  task automatic idle_check(input string name);
    step(0, 0, 0, 16'h0, 0);
    @(posedge clk);
    #2;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_frames"}, frame_count, m_frames);
    chk({name, "_sync_err"}, sync_err, m_err);
    chk({name, "_ovf"}, ovf_count, m_ovf);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_data"}, data_out, 0);
    chk({name, "_valid"}, valid_out, 0);
    chk({name, "_chan"}, chan_out, 0);
    chk({name, "_sync"}, sync_out, 0);
    chk({name, "_frames"}, frame_count, 0);
    chk({name, "_err"}, sync_err, 0);
    chk({name, "_ovf"}, ovf_count, 0);
`ifdef REQUANT_UNPACK_POWER_EN
    chk({name, "_power"}, power_out, 0);
`endif
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst     = 1'b0;
    ce      = 1'b1;
    arm     = 1'b1;
    sync_in = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    check_zero(name);
    @(negedge clk);
    rst     = 1'b1;
    ce      = 1'b0;
    arm     = 1'b0;
    sync_in = 1'b0;
  endtask

  // Monitor: every presented word must match the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual chan %0d required no word", chan_out);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", data_out, e.data);
        chk("word_chan", chan_out, e.chan);
        chk("word_sync", sync_out, e.sync);
`ifdef REQUANT_UNPACK_POWER_EN
        chk("word_power", power_out, e.pwr);
`endif
      end
    end else begin
      chk("sync_without_valid", sync_out, 0);
    end
  end

  initial begin
    rst     = 1'b0;
    ce      = 1'b0;
    arm     = 1'b0;
    sync_in = 1'b0;
    data_in = '0;
    ovf_in  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Sync without arm must produce nothing.
    for (int i = 0; i < 6; i++) step(1, 0, i % 2 == 0, 16'($urandom), 0);
    idle_check("no_arm");

    // Arm, overflowing words while waiting for sync, then one full frame.
    step(1, 1, 0, 16'h7F80, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h7F80, 1);
    step(1, 0, 1, 16'h7F80, 1);
    for (int i = 0; i < NCH; i++) step(1, 0, 0, 16'h7F80, (i >= 10 && i <= 12));
    idle_check("frame1");
    chk("frame1_count_const", frame_count, 1);
    chk("frame1_ovf_const", ovf_count, 3);

    // Second frame with sync on the last word: correctly aligned, no error.
    for (int i = 0; i < NCH; i++) step(1, 0, i == NCH - 1, 16'($urandom), 0);
    idle_check("frame2");
    chk("aligned_sync_err", sync_err, 0);
    chk("frame2_count_const", frame_count, 2);

    // Misaligned sync at next_chan 100.
    for (int i = 0; i < 100; i++) step(1, 0, 0, 16'($urandom), 0);
    step(1, 0, 1, 16'($urandom), 0);
    idle_check("misaligned");
    chk("misaligned_err_const", sync_err, 1);
    step(1, 0, 0, 16'($urandom), 0);

    // ce toggling across a full frame.
    for (int i = 0; i < 2 * NCH; i++) step(i % 2 == 0, 0, 0, 16'($urandom), $urandom_range(0, 3) == 0);
    idle_check("ce_toggle");

    step(1, 0, 0, 16'h8080, 0);
    step(1, 0, 0, 16'h0303, 0);
    step(1, 0, 0, 16'h7F81, 0);
    idle_check("extremes");

    // Randomized traffic with occasional re-arm and sync.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0,
           $urandom_range(0, 299) == 0, 16'($urandom), $urandom_range(0, 7) == 0);
    idle_check("random");

    // Reset mid-frame at channel 500.
    step(1, 1, 0, 16'h0, 0);
    step(1, 0, 1, 16'h0, 0);
    for (int i = 0; i < 500; i++) step(1, 0, 0, 16'($urandom), 1);
    do_reset("mid_reset");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 16'($urandom), 1);
    idle_check("post_reset");
    chk("post_reset_frames_const", frame_count, 0);

    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/requant_unpack.md
# requant_unpack

Receive-side counterpart of the requantizer. Accepts the packed 16-bit `{re[7:0], im[7:0]}` stream and its `sync_out` pulse, and aligns to the frame boundary. Restores each sample to the 24-bit `{re[11:0], im[11:0]}` format the requantizer consumes, tags it with its channel index, and counts frames, sync errors and flagged overflows. It sits on the receive side of the link, ahead of correlator or capture logic that expects pre-requant sample format.

## Interface

Parameters:
- `NCHAN`, 2048: channels per frame, power of two.
- `CHAN_W`, 11: log2(`NCHAN`).
- `FRAME_W`, 16: frame counter width.

Ports:
- `clk`  in  1: sole clock. One clock; reset is synchronous and active-low.
- `rst`  in  1: synchronous, active-low reset.
- `ce`  in  1: sample enable. All state advances only when `ce`=1, except reset.
- `arm`  in  1: re-arm request. Level, sampled on `ce`.
- `sync_in`  in  1: frame marker. The next `ce` word after the pulse is channel 0.
- `data_in`  in  16: `{re8, im8}`, two's complement.
- `ovf_in`  in  1: overflow flag accompanying `data_in`.
- `data_out`  out  24: `{re8, 4'b0, im8, 4'b0}`.
- `valid_out`  out  1: `data_out` and `chan_out` are valid this cycle.
- `chan_out`  out  `CHAN_W`: channel index of `data_out`.
- `sync_out`  out  1: asserted with the channel-0 word, one cycle.
- `frame_count`  out  `FRAME_W`: completed frames, wraps.
- `sync_err`  out  1: sticky misaligned-sync flag.
- `ovf_count`  out  16: count of words with `ovf_in`=1, saturating at 16'hFFFF.

## Operation

State machine with encoding WaitArm=0, WaitSync=1, Running=2:
- WaitArm: go to WaitSync on `ce & arm`.
- WaitSync: on `ce & sync_in`, go to Running with `next_chan`=0.
- Running, data handling: each `ce` word is emitted with `chan_out`=`next_chan`, then `next_chan` increments.
- Running, wrap: when the emitted word has `chan_out`=`NCHAN-1`, `next_chan` wraps to 0 and `frame_count` increments.
- Running, sync: `ce & sync_in` forces `next_chan`=0. If `next_chan` was not already 0 at that point, set `sync_err`.
- Running, re-arm: `ce & arm` returns to WaitSync. Data is not emitted from the next cycle onward.
- Simultaneous `arm` and `sync_in` in Running: `arm` wins; go to WaitSync.
- Simultaneous data word and `sync_in`: the word on the same `ce` cycle as `sync_in` belongs to the previous frame position. The sync affects only the following word.

Arithmetic:
- Dequantization is a shift left by 4 with zero fill; the sign bit is preserved in bit 11.
- `ovf_count` increments only on words emitted in Running.

Output behaviour:
- Outputs hold their values when `ce`=0.
- `valid_out` and `sync_out` are 0 when `ce`=0.

## Timing

Latency:
- One cycle: `data_in` sampled on edge N appears on `data_out` after edge N+1.
- `sync_out` coincides with the `valid_out` of channel 0.

Reset (`rst`=0 at an edge): state=WaitArm and all outputs clear:
- `data_out`=0
- `valid_out`=0
- `chan_out`=0
- `sync_out`=0
- `frame_count`=0
- `sync_err`=0
- `ovf_count`=0
- `next_chan`=0

Reset mid-frame discards the partial frame and is not counted.

Boundaries:
- `frame_count` wraps from all-ones to 0.
- `sync_err` clears only on reset.
- `ovf_count` saturates; it does not wrap.

## Configuration

- `REQUANT_UNPACK_POWER_EN` defined: adds output `power_out` [15:0] = re8² + im8², unsigned.
  - Registered with the same one-cycle latency as `data_out`.
  - Reset value 0.
  - Maximum value 32768 (both components at −128) fits in 16 bits.
- Not defined: the port and the multipliers are absent; all other behaviour is identical.

## Structure

- Shared package `requant_pkg`:
  - `requant_state_t` enum (WaitArm/WaitSync/Running), shared with the requantizer.
  - `REQ_NCHAN`=2048.
  - `REQ_IN_W`=12, `REQ_OUT_W`=8, `REQ_SHIFT`=4.
- Sub-module `requant_unpack_sample`:
  - Combinational split, shift and optional power computation for one `{re8, im8}` word.
  - The top level holds the FSM, counters and output registers.

## Test plan

- Arm, sync, then 2048 words with `data_in`=16'h7F80 -> channel 0 has `data_out`=24'h7F0800 with `sync_out`=1. `chan_out` runs 0..2047; `frame_count`=1 after the last word.
- Sync pulse at `next_chan`=100 -> `sync_err`=1. The next word has `chan_out`=0 and `sync_out`=1.
- Words with `ovf_in`=1 in WaitSync, then 3 such words in Running -> `ovf_count`=3.
- `ce` toggling 1/0 across a frame -> `valid_out` only on `ce` cycles; channel sequence is unbroken.
- `rst`=0 at channel 500, then release -> all outputs 0, state WaitArm. Sync without arm produces no output.
- `REQUANT_UNPACK_POWER_EN` defined, `data_in`=16'h8080 -> `power_out`=32768. `data_in`=16'h0303 -> `power_out`=18.
